// File: rtl/inv_chk_pkg.sv
// Shared types and limits for the inverter/buffer sweep checker.
package inv_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } chk_state_t;

  localparam int unsigned LATENCY_MAX = 4;
  localparam int unsigned WIDTH_MAX   = 12;

endpackage

// File: rtl/chk_delay_line.sv
// Fixed-depth shift register carrying {valid, exp, pat} alongside the DUT latency.
module chk_delay_line #(
  parameter int unsigned DW    = 9,
  parameter int unsigned DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  // At least one stage always exists; DEPTH=0 bypasses it and the stage is trimmed.
  localparam int unsigned N = (DEPTH == 0) ? 1 : DEPTH;

  logic [DW-1:0] stages [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < N; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = (DEPTH == 0) ? d : stages[N-1];

endmodule

// File: rtl/inv_sweep_checker.sv
// Sweeps all 2^WIDTH patterns onto an inverter/buffer DUT and scores its
// delayed response against the expected value.
module inv_sweep_checker
  import inv_chk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 1,
  parameter bit          INVERT  = 1'b1,
  parameter int unsigned ERR_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_pat
);

  localparam int unsigned DW  = 2 * WIDTH + 1;
  localparam int unsigned DCW = $clog2(LATENCY_MAX + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((LATENCY > 0) ? LATENCY - 1 : 0);

  chk_state_t       state, state_next;
  logic [WIDTH-1:0] cnt;
  logic             drv;
  logic [DCW-1:0]   drain_cnt;
  logic             last_driven;
  logic             accept;
  logic             mismatch;
  logic             err_sat;
  logic             pass_q;
  logic [DW-1:0]    line_in;
  logic [DW-1:0]    line_out;
  logic             tail_valid;
  logic [WIDTH-1:0] tail_exp;
  logic [WIDTH-1:0] tail_pat;

  // drv marks a_out as carrying a live pattern, so the pipeline entry
  // always describes exactly what the DUT sees this cycle.
  assign line_in = {drv, (INVERT ? ~a_out : a_out), a_out};

  chk_delay_line #(
    .DW    (DW),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line_in),
    .q     (line_out)
  );

  assign {tail_valid, tail_exp, tail_pat} = line_out;

  assign last_driven = drv && (a_out == '1);
  assign mismatch    = tail_valid && (y_in !== tail_exp);
  assign err_sat     = (err_count == '1);
  assign done        = (state == DONE);
  assign pass        = pass_q;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = DRIVE;
          accept     = 1'b1;
        end
      end
      DRIVE: begin
        if (last_driven) state_next = (LATENCY == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          state_next = DRIVE;
          accept     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stimulus side: the first DRIVE cycle loads pattern 0, so busy trails the
  // state register by one cycle and drops on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      cnt       <= '0;
      drv       <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= ((state == DRIVE) || (state == DRAIN)) &&
              ((state_next == DRIVE) || (state_next == DRAIN));
      case (state)
        DRIVE: begin
          drain_cnt <= '0;
          if (!last_driven) begin
            a_out <= cnt;
            cnt   <= cnt + WIDTH'(1);
            drv   <= 1'b1;
          end else begin
            drv <= 1'b0;
            cnt <= '0;
            if (LATENCY == 0) a_out <= '0;
          end
        end
        DRAIN: begin
          drv       <= 1'b0;
          drain_cnt <= drain_cnt + DCW'(1);
          if (drain_cnt == DRAIN_LAST) a_out <= '0;
        end
        default: begin
          a_out     <= '0;
          cnt       <= '0;
          drv       <= 1'b0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Scoreboard; pass folds in a mismatch landing on the DONE-entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_pat   <= '0;
      pass_q          <= 1'b0;
    end else if (accept) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_pat   <= '0;
      pass_q          <= 1'b0;
    end else begin
      if (mismatch) begin
        if (!err_sat) err_count <= err_count + ERR_W'(1);
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_pat   <= tail_pat;
        end
      end
      if ((state != DONE) && (state_next == DONE)) begin
        pass_q <= (err_count == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_inv_sweep_checker.sv
// Directed bench: four checker instances against modelled inverter/buffer DUTs.
module tb_inv_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] start_v = '0;
  logic [3:0] busy_v, done_v, pass_v, fev_v;
  logic [3:0] a_v   [4];
  logic [3:0] y_v   [4];
  logic [3:0] fep_v [4];
  logic [15:0] errc [4];
  logic [2:0] err_small;
  logic [1:0] dut_mode = 2'd0;
  logic [3:0] r1, r2, s1, s2;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // inst0: mode 0 registered inverter, 1 y[0] stuck-at-0, 2 two-cycle inverter
  always @(posedge clk) begin
    r1 <= ~a_v[0];
    r2 <= r1;
    s1 <= ~a_v[3];
    s2 <= s1;
  end
  assign y_v[0] = (dut_mode == 2'd2) ? r2 : (dut_mode == 2'd1) ? (r1 & 4'b1110) : r1;
  assign y_v[1] = ~a_v[1];
  assign y_v[2] = a_v[2];
  assign y_v[3] = s2;
  assign errc[3] = {13'd0, err_small};

  inv_sweep_checker #(.WIDTH(4), .LATENCY(1), .INVERT(1'b1), .ERR_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_out(a_v[0]), .y_in(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(errc[0]),
    .first_err_valid(fev_v[0]), .first_err_pat(fep_v[0]));

  inv_sweep_checker #(.WIDTH(4), .LATENCY(0), .INVERT(1'b1), .ERR_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_out(a_v[1]), .y_in(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(errc[1]),
    .first_err_valid(fev_v[1]), .first_err_pat(fep_v[1]));

  inv_sweep_checker #(.WIDTH(4), .LATENCY(0), .INVERT(1'b0), .ERR_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_out(a_v[2]), .y_in(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(errc[2]),
    .first_err_valid(fev_v[2]), .first_err_pat(fep_v[2]));

  inv_sweep_checker #(.WIDTH(4), .LATENCY(1), .INVERT(1'b1), .ERR_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a_out(a_v[3]), .y_in(y_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_small),
    .first_err_valid(fev_v[3]), .first_err_pat(fep_v[3]));

  // Stimulus only: pulses start (sampled at edge 0), optionally re-pulses it at
  // edge 'extra', and measures busy length and the edge at which done rises.
  task automatic run_sweep(input int i, input int extra, output int done_edge,
                           output int busy_cycles, output logic done0,
                           output logic [15:0] err0, output logic fev0);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    done0 = done_v[i];
    err0  = errc[i];
    fev0  = fev_v[i];
    done_edge   = -1;
    busy_cycles = 0;
    for (int e = 1; e <= 60 && done_edge < 0; e++) begin
      if (e == extra) start_v[i] = 1'b1;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      if (busy_v[i]) busy_cycles++;
      if (done_v[i]) done_edge = e;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_v[0] !== 4'd0)    begin n_bad++; $display("FAIL reset_a_out: got %h want 0", a_v[0]); end
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
    n_cmp++; if (done_v[0] !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass_v[0]); end
    n_cmp++; if (errc[0] !== 16'd0)  begin n_bad++; $display("FAIL reset_err: got %0d want 0", errc[0]); end
    n_cmp++; if (fev_v[0] !== 1'b0)  begin n_bad++; $display("FAIL reset_fev: got %b want 0", fev_v[0]); end
    n_cmp++; if (fep_v[0] !== 4'd0)  begin n_bad++; $display("FAIL reset_fep: got %h want 0", fep_v[0]); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_inv_pass();
    int de, bc; logic d0, f0; logic [15:0] e0;
    dut_mode = 2'd0;
    run_sweep(0, -1, de, bc, d0, e0, f0);
    n_cmp++; if (de !== 18)          begin n_bad++; $display("FAIL inv_done_edge: got %0d want 18", de); end
    n_cmp++; if (bc !== 17)          begin n_bad++; $display("FAIL inv_busy_len: got %0d want 17", bc); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_bad++; $display("FAIL inv_pass: got %b want 1", pass_v[0]); end
    n_cmp++; if (errc[0] !== 16'd0)  begin n_bad++; $display("FAIL inv_err: got %0d want 0", errc[0]); end
    n_cmp++; if (fev_v[0] !== 1'b0)  begin n_bad++; $display("FAIL inv_fev: got %b want 0", fev_v[0]); end
    n_cmp++; if (a_v[0] !== 4'd0)    begin n_bad++; $display("FAIL inv_a_idle: got %h want 0", a_v[0]); end
  endtask

  task automatic test_stuck_bit();
    int de, bc; logic d0, f0; logic [15:0] e0;
    dut_mode = 2'd1;
    run_sweep(0, -1, de, bc, d0, e0, f0);
    n_cmp++; if (de !== 18)          begin n_bad++; $display("FAIL stuck_done_edge: got %0d want 18", de); end
    n_cmp++; if (errc[0] !== 16'd8)  begin n_bad++; $display("FAIL stuck_err: got %0d want 8", errc[0]); end
    n_cmp++; if (fev_v[0] !== 1'b1)  begin n_bad++; $display("FAIL stuck_fev: got %b want 1", fev_v[0]); end
    n_cmp++; if (fep_v[0] !== 4'd0)  begin n_bad++; $display("FAIL stuck_fep: got %h want 0", fep_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b0) begin n_bad++; $display("FAIL stuck_pass: got %b want 0", pass_v[0]); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (done_v[0] !== 1'b1) begin n_bad++; $display("FAIL stuck_done_sticky: got %b want 1", done_v[0]); end
  endtask

  task automatic test_restart_from_done();
    int de, bc; logic d0, f0; logic [15:0] e0;
    dut_mode = 2'd0;
    run_sweep(0, -1, de, bc, d0, e0, f0);
    n_cmp++; if (d0 !== 1'b0)        begin n_bad++; $display("FAIL restart_done_clr: got %b want 0", d0); end
    n_cmp++; if (e0 !== 16'd0)       begin n_bad++; $display("FAIL restart_err_clr: got %0d want 0", e0); end
    n_cmp++; if (f0 !== 1'b0)        begin n_bad++; $display("FAIL restart_fev_clr: got %b want 0", f0); end
    n_cmp++; if (de !== 18)          begin n_bad++; $display("FAIL restart_done_edge: got %0d want 18", de); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_bad++; $display("FAIL restart_pass: got %b want 1", pass_v[0]); end
  endtask

  task automatic test_comb();
    int de, bc; logic d0, f0; logic [15:0] e0;
    run_sweep(1, -1, de, bc, d0, e0, f0);
    n_cmp++; if (de !== 17)          begin n_bad++; $display("FAIL comb_inv_done_edge: got %0d want 17", de); end
    n_cmp++; if (bc !== 16)          begin n_bad++; $display("FAIL comb_inv_busy_len: got %0d want 16", bc); end
    n_cmp++; if (pass_v[1] !== 1'b1) begin n_bad++; $display("FAIL comb_inv_pass: got %b want 1", pass_v[1]); end
    n_cmp++; if (errc[1] !== 16'd0)  begin n_bad++; $display("FAIL comb_inv_err: got %0d want 0", errc[1]); end
    run_sweep(2, -1, de, bc, d0, e0, f0);
    n_cmp++; if (de !== 17)          begin n_bad++; $display("FAIL comb_buf_done_edge: got %0d want 17", de); end
    n_cmp++; if (pass_v[2] !== 1'b1) begin n_bad++; $display("FAIL comb_buf_pass: got %b want 1", pass_v[2]); end
    n_cmp++; if (errc[2] !== 16'd0)  begin n_bad++; $display("FAIL comb_buf_err: got %0d want 0", errc[2]); end
  endtask

  // A 2-cycle DUT sees a_out=0 in the cycle before pattern 0, so pattern 0
  // matches by coincidence and patterns 1..15 all miscompare.
  task automatic test_late_dut();
    int de, bc; logic d0, f0; logic [15:0] e0;
    dut_mode = 2'd2;
    run_sweep(0, -1, de, bc, d0, e0, f0);
    n_cmp++; if (errc[0] !== 16'd15) begin n_bad++; $display("FAIL late_err: got %0d want 15", errc[0]); end
    n_cmp++; if (fep_v[0] !== 4'd1)  begin n_bad++; $display("FAIL late_fep: got %h want 1", fep_v[0]); end
    n_cmp++; if (pass_v[0] !== 1'b0) begin n_bad++; $display("FAIL late_pass: got %b want 0", pass_v[0]); end
    run_sweep(3, -1, de, bc, d0, e0, f0);
    n_cmp++; if (errc[3] !== 16'd7)  begin n_bad++; $display("FAIL sat_err: got %0d want 7", errc[3]); end
    n_cmp++; if (fev_v[3] !== 1'b1)  begin n_bad++; $display("FAIL sat_fev: got %b want 1", fev_v[3]); end
    n_cmp++; if (fep_v[3] !== 4'd1)  begin n_bad++; $display("FAIL sat_fep: got %h want 1", fep_v[3]); end
    n_cmp++; if (pass_v[3] !== 1'b0) begin n_bad++; $display("FAIL sat_pass: got %b want 0", pass_v[3]); end
  endtask

  task automatic test_start_ignored();
    int de, bc; logic d0, f0; logic [15:0] e0;
    dut_mode = 2'd0;
    run_sweep(0, 5, de, bc, d0, e0, f0);
    n_cmp++; if (de !== 18)          begin n_bad++; $display("FAIL ignore_done_edge: got %0d want 18", de); end
    n_cmp++; if (bc !== 17)          begin n_bad++; $display("FAIL ignore_busy_len: got %0d want 17", bc); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_bad++; $display("FAIL ignore_pass: got %b want 1", pass_v[0]); end
  endtask

  task automatic test_reset_mid();
    int de, bc; logic d0, f0; logic [15:0] e0;
    dut_mode = 2'd1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if (a_v[0] !== 4'd8)    begin n_bad++; $display("FAIL mid_a_out: got %h want 8", a_v[0]); end
    n_cmp++; if (errc[0] !== 16'd4)  begin n_bad++; $display("FAIL mid_err: got %0d want 4", errc[0]); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_v[0] !== 4'd0)    begin n_bad++; $display("FAIL abort_a_out: got %h want 0", a_v[0]); end
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_v[0]); end
    n_cmp++; if (errc[0] !== 16'd0)  begin n_bad++; $display("FAIL abort_err: got %0d want 0", errc[0]); end
    n_cmp++; if (fev_v[0] !== 1'b0)  begin n_bad++; $display("FAIL abort_fev: got %b want 0", fev_v[0]); end
    n_cmp++; if (fep_v[0] !== 4'd0)  begin n_bad++; $display("FAIL abort_fep: got %h want 0", fep_v[0]); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    n_cmp++; if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL noresume_busy: got %b want 0", busy_v[0]); end
    n_cmp++; if (done_v[0] !== 1'b0) begin n_bad++; $display("FAIL noresume_done: got %b want 0", done_v[0]); end
    n_cmp++; if (a_v[0] !== 4'd0)    begin n_bad++; $display("FAIL noresume_a_out: got %h want 0", a_v[0]); end
    dut_mode = 2'd0;
    run_sweep(0, -1, de, bc, d0, e0, f0);
    n_cmp++; if (de !== 18)          begin n_bad++; $display("FAIL fresh_done_edge: got %0d want 18", de); end
    n_cmp++; if (pass_v[0] !== 1'b1) begin n_bad++; $display("FAIL fresh_pass: got %b want 1", pass_v[0]); end
  endtask

  initial begin
    test_reset();
    test_inv_pass();
    test_stuck_bit();
    test_restart_from_done();
    test_comb();
    test_late_dut();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
